// File: rtl/tiler_pkg.sv
// -----------------------------------------------------------------------------
// tiler_pkg
// Shared definitions for the YCbCr 8x8 block tiler:
//   BLK / BLK_SZ   : block edge length and samples per block
//   rd_state_t     : read-side FSM state encoding
//   ZIGZAG         : JPEG zigzag LUT of {r[2:0], c[2:0]} (TILER_ZIGZAG_EN builds only)
//   band_addr_w()  : address width of one 8-line bank
// Optional feature macro: TILER_ZIGZAG_EN
// -----------------------------------------------------------------------------
package tiler_pkg;

  localparam int BLK    = 8;
  localparam int BLK_SZ = 64;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

`ifdef TILER_ZIGZAG_EN
  // Entry k holds the raster position {r, c} of zigzag index k inside a block.
  localparam logic [5:0] ZIGZAG [BLK_SZ] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
`endif

  // Bits needed to address one bank of 8 lines.
  function automatic int band_addr_w(input int img_w);
    return $clog2(BLK * img_w);
  endfunction

endpackage

// File: rtl/tiler_bank_ram.sv
// -----------------------------------------------------------------------------
// tiler_bank_ram
// Simple dual-port RAM holding both ping-pong banks. The address MSB selects
// the bank; the lower bits address a pixel within the 8-line band.
// Ports:
//   clk    : clock
//   we     : write enable
//   waddr  : write address {bank, band_addr}
//   wdata  : write data
//   raddr  : read address {bank, band_addr}
//   rdata  : registered read data (1-cycle latency)
// Contents are never reset.
// -----------------------------------------------------------------------------
module tiler_bank_ram #(
  parameter int AW = 10,
  parameter int WW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);

  // Sized to the full address space so the bank MSB always lands in range.
  logic [WW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ycbcr_block_tiler.sv
// -----------------------------------------------------------------------------
// ycbcr_block_tiler
// Converts raster-order YCbCr pixels into 8x8 blocks in block-raster order.
// One 8-line bank is written while the other is read out (ping-pong).
// Ports:
//   iClk, iRst_n        : clock, synchronous active-low reset
//   iValid, iY/iCb/iCr  : raster input pixel
//   oValid, oY/oCb/oCr  : block-ordered output sample
//   oBlkStart           : first sample of each 8x8 block
//   oFrameEnd           : last sample of the final block of the frame
//   oOverflow           : sticky, a band completed while a readout was active
// Optional feature macro: TILER_ZIGZAG_EN (zigzag order inside each block)
// -----------------------------------------------------------------------------
module ycbcr_block_tiler
  import tiler_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = 8
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iValid,
  input  logic [DW-1:0] iY,
  input  logic [DW-1:0] iCb,
  input  logic [DW-1:0] iCr,
  output logic          oValid,
  output logic [DW-1:0] oY,
  output logic [DW-1:0] oCb,
  output logic [DW-1:0] oCr,
  output logic          oBlkStart,
  output logic          oFrameEnd,
  output logic          oOverflow
);

  localparam int BAW = band_addr_w(IMG_W);
  localparam int CW  = $clog2(IMG_W);
  localparam int FLW = $clog2(IMG_H);
  localparam int WW  = 3 * DW;

  // ---------------- write side ----------------
  logic [CW-1:0]  col_reg;
  logic [FLW-1:0] fline_reg;     // frame line; low 3 bits are the band line
  logic           wbank_reg;
  logic           line_end;
  logic           trigger;
  logic           last_band;
  logic [BAW-1:0] waddr_band;

  assign line_end   = iValid && (col_reg == CW'(IMG_W - 1));
  assign trigger    = line_end && (fline_reg[2:0] == 3'd7);
  assign last_band  = (fline_reg == FLW'(IMG_H - 1));
  assign waddr_band = BAW'(fline_reg[2:0]) * BAW'(IMG_W) + BAW'(col_reg);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      col_reg   <= '0;
      fline_reg <= '0;
      wbank_reg <= 1'b0;
    end else if (iValid) begin
      if (line_end) begin
        col_reg   <= '0;
        fline_reg <= last_band ? '0 : fline_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
      if (trigger) begin
        wbank_reg <= ~wbank_reg;
      end
    end
  end

  // ---------------- read FSM ----------------
  rd_state_t      state_reg, state_next;
  logic [BAW-1:0] rd_cnt_reg, rd_cnt_next;
  logic           rbank_reg, rbank_next;
  logic           flast_reg, flast_next;   // band being read ends the frame
  logic           ovf_reg, ovf_next;
  logic           rd_last;

  assign rd_last = (rd_cnt_reg == BAW'(BLK * IMG_W - 1));

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_reg  <= IDLE;
      rd_cnt_reg <= '0;
      rbank_reg  <= 1'b0;
      flast_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rd_cnt_reg <= rd_cnt_next;
      rbank_reg  <= rbank_next;
      flast_reg  <= flast_next;
      ovf_reg    <= ovf_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rd_cnt_next = rd_cnt_reg;
    rbank_next  = rbank_reg;
    flast_next  = flast_reg;
    ovf_next    = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (trigger) begin
          state_next  = READ;
          rd_cnt_next = '0;
          rbank_next  = wbank_reg;   // the bank that just filled
          flast_next  = last_band;
        end
      end
      READ: begin
        if (rd_last) begin
          // A band finishing on the very cycle readout ends chains directly.
          if (trigger) begin
            rd_cnt_next = '0;
            rbank_next  = wbank_reg;
            flast_next  = last_band;
          end else begin
            state_next  = IDLE;
            rd_cnt_next = '0;
          end
        end else begin
          rd_cnt_next = rd_cnt_reg + 1'b1;
          if (trigger) begin
            ovf_next = 1'b1;         // new band ignored, readout carries on
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read address: rd_cnt = {block, in-block index}.
  logic [5:0]     blk_idx;
  logic [5:0]     pos;
  logic [BAW-1:0] blk_base;
  logic [BAW-1:0] raddr_band;

  assign blk_idx = rd_cnt_reg[5:0];
`ifdef TILER_ZIGZAG_EN
  assign pos = ZIGZAG[blk_idx];
`else
  assign pos = blk_idx;
`endif
  assign blk_base   = (rd_cnt_reg >> $clog2(BLK_SZ)) << $clog2(BLK);
  assign raddr_band = BAW'(pos[5:3]) * BAW'(IMG_W) + blk_base + BAW'(pos[2:0]);

  logic [WW-1:0] rdata;

  tiler_bank_ram #(
    .AW(BAW + 1),
    .WW(WW)
  ) u_ram (
    .clk   (iClk),
    .we    (iValid),
    .waddr ({wbank_reg, waddr_band}),
    .wdata ({iY, iCb, iCr}),
    .raddr ({rbank_reg, raddr_band}),
    .rdata (rdata)
  );

  // Stage 1 tracks the RAM read cycle; stage 2 registers the outputs.
  logic vld1_reg, bs1_reg, fe1_reg;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      vld1_reg  <= 1'b0;
      bs1_reg   <= 1'b0;
      fe1_reg   <= 1'b0;
      oValid    <= 1'b0;
      oBlkStart <= 1'b0;
      oFrameEnd <= 1'b0;
      oY        <= '0;
      oCb       <= '0;
      oCr       <= '0;
    end else begin
      vld1_reg  <= (state_reg == READ);
      bs1_reg   <= (state_reg == READ) && (blk_idx == 6'd0);
      fe1_reg   <= (state_reg == READ) && rd_last && flast_reg;
      oValid    <= vld1_reg;
      oBlkStart <= bs1_reg;
      oFrameEnd <= fe1_reg;
      if (vld1_reg) begin
        {oY, oCb, oCr} <= rdata;
      end
    end
  end

  assign oOverflow = ovf_reg;

endmodule

// File: doc/ycbcr_block_tiler.md
Name: ycbcr_block_tiler

Overview:
- Downstream stage of the RGB-to-YCbCr converter.
- Accepts YCbCr pixels in raster order, one per clock at most, and re-emits them as 8x8 blocks in block-raster order for the JPEG DCT stage.
- Uses a ping-pong buffer of two 8-line banks: one bank is written while the other is read out.

Parameters:
- IMG_W, 64, image width in pixels; multiple of 8, >= 8.
- IMG_H, 64, image height in lines; multiple of 8, >= 8.
- DW, 8, bits per colour component.

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  synchronous reset, active low.
- iValid  in  1  input pixel valid this cycle.
- iY  in  DW  luma.
- iCb  in  DW  blue chroma.
- iCr  in  DW  red chroma.
- oValid  out  1  output sample valid.
- oY  out  DW  luma in block order.
- oCb  out  DW  blue chroma in block order.
- oCr  out  DW  red chroma in block order.
- oBlkStart  out  1  high with sample 0 of each 8x8 block.
- oFrameEnd  out  1  high with the last sample of the last block of the frame.
- oOverflow  out  1  sticky error flag.

Behaviour:
- Reset (iRst_n=0 at a clock edge):
  - oValid, oBlkStart, oFrameEnd, oOverflow go to 0.
  - oY/oCb/oCr go to 0.
  - Write column/line/bank counters, read counters and read FSM go to 0/IDLE.
  - RAM contents are not cleared.
  - Reset mid-frame discards the partial frame. The next iValid is pixel (0,0).
- No backpressure exists; the consumer must always accept output.
- Write side:
  - On iValid, store {iY,iCb,iCr} at address line*IMG_W+col of the write bank.
  - col wraps at IMG_W-1 and increments line (0..7).
  - On the last pixel of line 7, the write bank toggles and the read FSM is triggered.
  - A frame line counter wraps at IMG_H-1.
- Read FSM:
  - IDLE: wait for the trigger, then go to READ.
  - READ: one RAM read per cycle from the previous write bank.
    - Order: block b = 0..IMG_W/8-1, row r = 0..7, column c = 0..7.
    - Address = r*IMG_W + b*8 + c.
    - After address 8*IMG_W-1 has been issued, return to IDLE.
- Latency:
  - RAM read is synchronous, 1 cycle.
  - If the last pixel of band line 7 is written at edge N, the read address is issued at N+1 and the first oValid appears after edge N+2.
  - Output is continuous for 8*IMG_W cycles.
- Flag timing:
  - oBlkStart is aligned with the output whose r=0, c=0.
  - oFrameEnd is aligned with the final sample of the band starting at frame line IMG_H-8.
- Overflow:
  - If a trigger occurs while READ is still active, set oOverflow (sticky until reset).
  - The new trigger is ignored and the in-progress readout continues.
  - This is impossible at an input rate of 1 pixel/clock or less. It is checked to catch integration faults.
- Simultaneous events: a trigger in the same cycle the FSM returns to IDLE is accepted, with no gap and no overflow.

Optional Feature:
- Macro TILER_ZIGZAG_EN.
- Defined: within each block, samples are emitted in JPEG zigzag order. (r,c) comes from the zigzag LUT indexed by the 0..63 in-block counter. Latency is unchanged. oBlkStart stays on index 0 and oFrameEnd on index 63 of the final block.
- Undefined: row-major order within each block, and no LUT is synthesized.

Decomposition:
- Package tiler_pkg:
  - BLK=8, BLK_SZ=64.
  - Read FSM state typedef {IDLE, READ}.
  - 64-entry zigzag constant array of {r[2:0], c[2:0]}.
  - Address-width function clog2(8*IMG_W).
- Sub-module tiler_bank_ram: simple dual-port RAM, 2*8*IMG_W x 3*DW, one write port, synchronous read port. The bank select is the address MSB.

Test Plan:
- Reset values:
  - Assert iRst_n=0 for 3 clocks with iValid=1, then release.
  - Expect all outputs 0 throughout reset and no oValid until 8*IMG_W pixels have been written after release.
- Ramp, 64x64, continuous iValid:
  - Input Y=x, Cb=y, Cr=8'h80.
  - First oValid exactly 2 cycles after pixel (63,7).
  - Block 0 Y sequence 0..7 repeated 8 times. Cb = r, with 8 copies per row.
  - Block 1 Y = 8..15.
  - oBlkStart every 64 samples.
  - oFrameEnd on output sample 4096 with Y=63, Cb=63.
- Gapped input:
  - iValid toggles 1,0,1,0 with the same ramp.
  - Output content is identical to the continuous case.
  - Each band emits 512 contiguous valid cycles, oOverflow=0.
- Reset mid-frame:
  - Reset after 300 pixels, then send a full frame.
  - Expect first-band output equal to the clean run, and no stale data ordering.
- Overflow injection:
  - Force a second trigger (bench override of the write counter) while READ is active.
  - Expect oOverflow=1 sticky, and the current band still completes all 512 samples.
- TILER_ZIGZAG_EN build, ramp input:
  - Block 0 (Y,Cb) sequence is (0,0),(1,0),(0,1),(0,2),(1,1),(2,0),...
  - The last sample is (7,7) with oFrameEnd aligned on the final block.
